id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection.
- Sits between the decode stage and EX.
- Its registered ex_rs/ex_rt/ex_dst/ex_reg_write outputs feed the operand-forwarding control and the EX operand muxes.
- Inserts bubbles on load-use hazards and branch flushes, freezes on memory back-pressure, and counts stall cycles for performance monitoring.

Parameters:
- DATA_W, 32, operand data width
- REG_W, 5, register index width
- CNT_W, 16, stall performance counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode stage holds a real instruction
- id_rs  in  REG_W  source register 1 index
- id_rt  in  REG_W  source register 2 index
- id_dst  in  REG_W  destination register index
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_reg_write  in  1  instruction writes id_dst
- id_mem_read  in  1  instruction is a load
- id_rs_data  in  DATA_W  regfile read data for rs
- id_rt_data  in  DATA_W  regfile read data for rt
- flush  in  1  branch/jump resolved taken; squash decode instruction
- mem_busy  in  1  memory stage back-pressure; freeze pipeline
- ex_valid  out  1  EX holds a real instruction
- ex_rs  out  REG_W  registered rs index
- ex_rt  out  REG_W  registered rt index
- ex_dst  out  REG_W  registered destination
- ex_reg_write  out  1  registered write enable
- ex_mem_read  out  1  registered load flag
- ex_rs_data  out  DATA_W  registered rs data
- ex_rt_data  out  DATA_W  registered rt data
- stall  out  1  hold PC and IF/ID register this cycle
- stall_cnt  out  CNT_W  saturating count of load-use bubble cycles

Behaviour:
- Clocking/reset: single clock `clk`. Reset is synchronous and active-high on `rst`.
- Reset (rst=1 at posedge): all ex_* outputs cleared to 0 (a bubble); stall_cnt=0. rst has priority over every other input.
- Load-use hazard (combinational) asserts when all of the following hold:
  - ex_valid & ex_mem_read & (ex_dst != 0) & id_valid & ~flush
  - and (id_uses_rs & id_rs==ex_dst) OR (id_uses_rt & id_rt==ex_dst)
- stall = load_use | mem_busy, combinational, no latency. stall is 0 while rst=1.
- Register update at each posedge, first matching rule wins:
  1. rst: clear as above.
  2. mem_busy=1: hold all ex_* registers unchanged. stall_cnt unchanged.
  3. flush=1: load a bubble (ex_valid, ex_reg_write, ex_mem_read = 0; indices and data = 0).
  4. load_use=1: load a bubble (same encoding). stall_cnt increments by 1 and saturates at all-ones (no wrap).
  5. Otherwise: capture all id_* fields. ex_valid=id_valid. ex_reg_write=id_reg_write&id_valid. ex_mem_read=id_mem_read&id_valid.
- Bubble invariant: whenever ex_valid=0, ex_reg_write=0 and ex_mem_read=0. Downstream forwarding must never match a bubble.
- Register 0: a load with ex_dst=0 never causes a stall.
- Latency: one cycle from id_* to ex_*. A load-use stall lasts exactly one cycle. On the next cycle EX holds the bubble (ex_mem_read=0), so the hazard clears and the dependent instruction is captured. Its load operand is then forwarded from MEM.
- Simultaneous events:
  - flush with load_use: flush wins. No stall; no count increment.
  - mem_busy with load_use: freeze wins. stall=1; no count increment. The hazard is re-evaluated after mem_busy drops.
- rst asserted mid-stall: the bubble is cleared and the counter zeroed at the same edge. stall=0 during reset.

Test Plan:
- Load then use: cycle N captures a load with id_dst=5, id_mem_read=1. At N+1, id_rs=5 with id_uses_rs=1 -> stall=1 that cycle. EX gets a bubble at N+2 (ex_valid=0) and stall_cnt=1. The dependent instruction is captured at N+3 with ex_rs=5.
- Load to r0 (ex_dst=0) followed by an instruction reading r0 -> stall=0; instruction captured next cycle; stall_cnt stays 0.
- Dependent instruction with id_uses_rt=0 and id_rt==ex_dst of the load -> no stall. The same with id_uses_rt=1 -> stall.
- flush=1 with a valid id instruction (id_reg_write=1, id_dst=7) -> next cycle ex_valid=0, ex_reg_write=0, ex_dst=0. flush asserted during a load-use hazard -> stall=0 and stall_cnt unchanged.
- mem_busy held 3 cycles while EX holds ex_dst=9, ex_rs_data=0xDEADBEEF -> outputs stable for all 3 cycles with stall=1. Normal capture resumes on the first cycle after release.
- Force stall_cnt to all-ones via 2^CNT_W consecutive hazards (use CNT_W=4: 16 hazards) -> value stays 0xF on the 17th. Then assert rst mid-hazard -> stall_cnt=0, ex_valid=0, stall=0 during rst.

Source files
------------

// File: rtl/id_ex_stage.sv
`default_nettype none
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, bubble
// insertion on flush/hazard, freeze on memory back-pressure and a stall counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_dst,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic              flush,
  input  logic              mem_busy,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_dst,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic load_in_ex;
  logic src_match;
  logic load_use;

  // A load writing r0 never produces a usable value, so it can never cause a hazard.
  assign load_in_ex = ex_valid && ex_mem_read && (ex_dst != '0);
  assign src_match  = (id_uses_rs && (id_rs == ex_dst)) ||
                      (id_uses_rt && (id_rt == ex_dst));
  assign load_use   = load_in_ex && id_valid && !flush && src_match;
  assign stall      = !rst && (load_use || mem_busy);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_dst       <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      stall_cnt    <= '0;
    end else if (mem_busy) begin
      // Freeze: everything holds, and a pending hazard is re-evaluated on release.
    end else if (flush || load_use) begin
      ex_valid     <= 1'b0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_dst       <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      if (!flush && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end else begin
      ex_valid     <= id_valid;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_dst       <= id_dst;
      ex_reg_write <= id_reg_write && id_valid;
      ex_mem_read  <= id_mem_read && id_valid;
      ex_rs_data   <= id_rs_data;
      ex_rt_data   <= id_rt_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// tb_id_ex_stage: directed scenarios plus randomized traffic, checked every cycle
// against a behavioural model of the EX-stage contents and the stall counter.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 4;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [REG_W-1:0]  id_rs, id_rt, id_dst;
  logic              id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic [DATA_W-1:0] id_rs_data, id_rt_data;
  logic              flush, mem_busy;
  logic              ex_valid;
  logic [REG_W-1:0]  ex_rs, ex_rt, ex_dst;
  logic              ex_reg_write, ex_mem_read;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_dst(id_dst), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .flush(flush),
    .mem_busy(mem_busy), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .stall(stall),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Model of what EX holds: an instruction record (all-zero record = bubble).
  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rs, rt, dst;
    logic              wr, ld;
    logic [DATA_W-1:0] d1, d2;
  } ex_rec_t;

  ex_rec_t m_ex  = '0;
  int      m_cnt = 0;

  // True when the decode instruction consumes the result of a load still in EX.
  function automatic bit needs_loaded_value();
    if (!(m_ex.valid && m_ex.ld) || m_ex.dst == 0 || !id_valid || flush) return 1'b0;
    return (id_uses_rs && id_rs == m_ex.dst) || (id_uses_rt && id_rt == m_ex.dst);
  endfunction

  function automatic ex_rec_t decode_rec();
    ex_rec_t r;
    r.valid = id_valid;
    r.rs = id_rs;  r.rt = id_rt;  r.dst = id_dst;
    r.wr = id_reg_write & id_valid;
    r.ld = id_mem_read & id_valid;
    r.d1 = id_rs_data;  r.d2 = id_rt_data;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ex  <= '0;
      m_cnt <= 0;
    end else if (mem_busy) begin
      m_ex <= m_ex;
    end else if (flush) begin
      m_ex <= '0;
    end else if (needs_loaded_value()) begin
      m_ex  <= '0;
      m_cnt <= (m_cnt >= MAXC) ? MAXC : m_cnt + 1;
    end else begin
      m_ex <= decode_rec();
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_stall", {63'd0, stall}, {63'd0, !rst && (mem_busy || needs_loaded_value())});
      chk("m_ex_valid", {63'd0, ex_valid}, {63'd0, m_ex.valid});
      chk("m_ex_rs", {59'd0, ex_rs}, {59'd0, m_ex.rs});
      chk("m_ex_rt", {59'd0, ex_rt}, {59'd0, m_ex.rt});
      chk("m_ex_dst", {59'd0, ex_dst}, {59'd0, m_ex.dst});
      chk("m_ex_reg_write", {63'd0, ex_reg_write}, {63'd0, m_ex.wr});
      chk("m_ex_mem_read", {63'd0, ex_mem_read}, {63'd0, m_ex.ld});
      chk("m_ex_rs_data", {32'd0, ex_rs_data}, {32'd0, m_ex.d1});
      chk("m_ex_rt_data", {32'd0, ex_rt_data}, {32'd0, m_ex.d2});
      chk("m_stall_cnt", {60'd0, stall_cnt}, 64'(m_cnt));
      if (!ex_valid) chk("bubble_inv", {62'd0, ex_reg_write, ex_mem_read}, 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input int rs, input int rt, input int dst,
                        input logic urs, input logic urt, input logic wr,
                        input logic ld, input logic [DATA_W-1:0] d1);
    id_valid = v;  id_rs = REG_W'(rs);  id_rt = REG_W'(rt);  id_dst = REG_W'(dst);
    id_uses_rs = urs;  id_uses_rt = urt;  id_reg_write = wr;  id_mem_read = ld;
    id_rs_data = d1;  id_rt_data = ~d1;
  endtask

  initial begin
    rst = 1'b1;  flush = 1'b0;  mem_busy = 1'b1;
    set_id(1, 5, 5, 5, 1, 1, 1, 1, 32'h1);
    step();
    chk_en = 1'b1;
    step();
    @(negedge clk);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_cnt", {60'd0, stall_cnt}, 64'd0);
    rst = 1'b0;  mem_busy = 1'b0;

    // Load then dependent use through rs.
    set_id(1, 1, 2, 5, 1, 1, 1, 1, 32'h100);
    step();
    set_id(1, 5, 3, 6, 1, 1, 1, 0, 32'h200);
    @(negedge clk);
    chk("lu_stall", {63'd0, stall}, 64'd1);
    step();
    @(negedge clk);
    chk("lu_bubble", {63'd0, ex_valid}, 64'd0);
    chk("lu_cnt", {60'd0, stall_cnt}, 64'd1);
    step();
    @(negedge clk);
    chk("lu_capture_valid", {63'd0, ex_valid}, 64'd1);
    chk("lu_capture_rs", {59'd0, ex_rs}, 64'd5);

    // Load to r0 never stalls.
    set_id(1, 1, 2, 0, 1, 1, 1, 1, 32'h300);
    step();
    set_id(1, 0, 0, 6, 1, 1, 1, 0, 32'h400);
    @(negedge clk);
    chk("r0_stall", {63'd0, stall}, 64'd0);
    step();
    @(negedge clk);
    chk("r0_capture", {63'd0, ex_valid}, 64'd1);
    chk("r0_cnt", {60'd0, stall_cnt}, 64'd1);

    // rt dependence only matters when rt is actually read.
    set_id(1, 1, 2, 8, 1, 1, 1, 1, 32'h500);
    step();
    set_id(1, 3, 8, 6, 1, 0, 1, 0, 32'h600);
    @(negedge clk);
    chk("rt_unused_stall", {63'd0, stall}, 64'd0);
    step();
    set_id(1, 1, 2, 8, 1, 1, 1, 1, 32'h700);
    step();
    set_id(1, 3, 8, 6, 1, 1, 1, 0, 32'h800);
    @(negedge clk);
    chk("rt_used_stall", {63'd0, stall}, 64'd1);
    step();
    @(negedge clk);
    chk("rt_cnt", {60'd0, stall_cnt}, 64'd2);

    // Flush squashes a valid writer, and overrides a load-use hazard.
    set_id(1, 1, 2, 7, 1, 1, 1, 0, 32'h900);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_valid", {63'd0, ex_valid}, 64'd0);
    chk("fl_wr", {63'd0, ex_reg_write}, 64'd0);
    chk("fl_dst", {59'd0, ex_dst}, 64'd0);
    set_id(1, 1, 2, 4, 1, 1, 1, 1, 32'hA00);
    step();
    set_id(1, 4, 2, 6, 1, 1, 1, 0, 32'hB00);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_lu_stall", {63'd0, stall}, 64'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_lu_cnt", {60'd0, stall_cnt}, 64'd2);

    // Memory back-pressure freezes EX for three cycles.
    set_id(1, 1, 2, 9, 1, 1, 1, 0, 32'hDEADBEEF);
    step();
    set_id(1, 3, 4, 10, 1, 1, 1, 0, 32'h12345678);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_stall", {63'd0, stall}, 64'd1);
      chk("busy_dst", {59'd0, ex_dst}, 64'd9);
      chk("busy_data", {32'd0, ex_rs_data}, 64'h0000_0000_DEAD_BEEF);
      step();
    end
    mem_busy = 1'b0;
    step();
    @(negedge clk);
    chk("busy_resume", {59'd0, ex_dst}, 64'd10);

    // Saturate the counter, then reset in the middle of a hazard.
    for (int i = 0; i < 17; i++) begin
      set_id(1, 1, 2, 5, 1, 1, 1, 1, 32'h0);
      step();
      set_id(1, 5, 2, 6, 1, 1, 1, 0, 32'h0);
      step();
    end
    @(negedge clk);
    chk("sat_cnt", {60'd0, stall_cnt}, 64'hF);
    set_id(1, 1, 2, 5, 1, 1, 1, 1, 32'h0);
    step();
    set_id(1, 5, 2, 6, 1, 1, 1, 0, 32'h0);
    @(negedge clk);
    chk("sat_hz_stall", {63'd0, stall}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_stall", {63'd0, stall}, 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_cnt", {60'd0, stall_cnt}, 64'd0);
    chk("rst_mid_valid", {63'd0, ex_valid}, 64'd0);

    // Randomized traffic with small register indices to make hazards frequent.
    for (int i = 0; i < 3000; i++) begin
      set_id(1'($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), $urandom);
      flush    = ($urandom_range(0, 7) == 0);
      mem_busy = ($urandom_range(0, 5) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;  flush = 1'b0;  mem_busy = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
